// File: rtl/acc_pkg.sv
// Shared types for the accumulator readout engine: FSM states, output FIFO entry, FIFO depth.
package acc_pkg;

    localparam int ACC_RD_FIFO_DEPTH = 2;
    localparam int ACC_DATA_WIDTH    = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } acc_rd_state_t;

    typedef struct packed {
        logic [ACC_DATA_WIDTH-1:0] data;
        logic                      last;
    } acc_rd_entry_t;

endpackage

// File: rtl/ram_if.sv
// Single-port RAM access bundle; a read master drives en/addr, a write master drives en/we/addr/wdata.
interface ram_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport read_master  (output en, output addr, input rdata);
    modport write_master (output en, output we, output addr, output wdata);
endinterface

// File: rtl/acc_rd_fifo.sv
// Two-entry synchronous FIFO buffering returned read data ahead of the output stream.
module acc_rd_fifo
    import acc_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  acc_rd_entry_t push_entry,
    input  logic          pop,
    output acc_rd_entry_t head,
    output logic [1:0]    count
);

    acc_rd_entry_t mem [ACC_RD_FIFO_DEPTH];
    logic          wr_ptr;
    logic          rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ACC_RD_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/acc_readout.sv
// Drains a contiguous accumulator RAM range onto a valid/ready stream, optionally zeroing each word read.
module acc_readout
    import acc_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = ACC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  clear_en,
    output logic                  busy,
    output logic                  done,
    ram_if.read_master            rd_port,
    ram_if.write_master           clr_port,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

    acc_rd_state_t         state;
    acc_rd_state_t         state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH:0]   remain;
    logic                  clr_q;

    logic                  issue;
    logic                  credit_ok;
    logic                  pop;
    logic                  last_hs;
    logic                  job_start;
    logic                  empty_start;

    logic                  vld_p1;
    logic                  last_p1;
    logic                  clr_p1;
    logic [ADDR_WIDTH-1:0] clr_addr_p1;
    logic                  done_q;

    acc_rd_entry_t         push_entry;
    acc_rd_entry_t         head;
    logic [1:0]            fifo_count;

    assign pop         = m_valid & m_ready;
    assign last_hs     = pop & head.last;
    assign job_start   = (state == IDLE) && start && (len != '0);
    assign empty_start = (state == IDLE) && start && (len == '0);

    // Buffered words plus the read still in flight must leave room for the one we are about to issue.
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, vld_p1}) < (3'd2 + {2'b00, pop});

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (job_start) state_nxt = RUN;
            end
            RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (remain == LEN_ONE) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue stage: address walk, remaining count, job configuration
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cur_addr <= '0;
            remain   <= '0;
            clr_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= empty_start || ((state == DRAIN) && last_hs);
            if (job_start) begin
                cur_addr <= base_addr;
                remain   <= len;
                clr_q    <= clear_en;
            end else if (issue) begin
                cur_addr <= cur_addr + 1'b1;
                remain   <= remain - LEN_ONE;
            end
        end
    end

    // Return stage: rdata arrives, tagged entry is pushed, zero-write goes out
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            clr_p1      <= 1'b0;
            clr_addr_p1 <= '0;
        end else begin
            vld_p1  <= issue;
            last_p1 <= issue && (remain == LEN_ONE);
            clr_p1  <= issue && clr_q;
            if (issue) clr_addr_p1 <= cur_addr;
        end
    end

    assign push_entry.data = rd_port.rdata;
    assign push_entry.last = last_p1;

    acc_rd_fifo u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (vld_p1),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count)
    );

    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = m_valid ? head.data : '0;
    assign m_last  = m_valid & head.last;

    assign busy = (state != IDLE);
    assign done = done_q;

    assign rd_port.en   = issue;
    assign rd_port.addr = cur_addr;

    assign clr_port.en    = clr_p1;
    assign clr_port.we    = clr_p1;
    assign clr_port.addr  = clr_addr_p1;
    assign clr_port.wdata = '0;

endmodule

// File: tb/tb_acc_readout.sv
// Randomized self-checking bench for acc_readout with a RAM model and a range-based stream reference.
module tb_acc_readout;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] len = '0;
    logic        clear_en = 1'b0;
    logic        busy, done;
    logic        m_valid, m_last;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;

    ram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) rd_if ();
    ram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) clr_if ();

    assign rd_if.we     = 1'b0;
    assign rd_if.wdata  = '0;
    assign clr_if.rdata = '0;

    acc_readout #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .clear_en  (clear_en),
        .busy      (busy),
        .done      (done),
        .rd_port   (rd_if),
        .clr_port  (clr_if),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered read, write port used only for zero-writes
    logic [31:0] ram [1024];
    always @(posedge clk) begin
        if (rd_if.en) rd_if.rdata <= ram[rd_if.addr];
        if (clr_if.en && clr_if.we) ram[clr_if.addr] = clr_if.wdata;
    end

    int rdy_mode = 0;
    int pidx = 0;
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: begin
                m_ready = ((pidx % 4) == 0) || ((pidx % 4) == 3);
                pidx++;
            end
            default: m_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Observation log, filled at the falling edge
    int          rd_a[$], rd_c[$], clr_a[$], clr_c[$], beat_c[$], done_c[$];
    logic [31:0] beat_d[$];
    bit          beat_l[$];
    int          busy_cnt, first_valid, stab_viol, credit_viol, clr_bad, n_iss, n_hs;
    bit          prev_stall;
    logic [31:0] prev_d;
    bit          prev_l;

    task automatic clear_log();
        rd_a.delete(); rd_c.delete(); clr_a.delete(); clr_c.delete();
        beat_c.delete(); beat_d.delete(); beat_l.delete(); done_c.delete();
        busy_cnt = 0; first_valid = -1; stab_viol = 0; credit_viol = 0; clr_bad = 0;
        n_iss = 0; n_hs = 0; prev_stall = 0; pidx = 0;
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (rd_if.en) begin
                rd_a.push_back(int'(rd_if.addr)); rd_c.push_back(cyc); n_iss++;
            end
            if (clr_if.en) begin
                clr_a.push_back(int'(clr_if.addr)); clr_c.push_back(cyc);
                if (clr_if.we !== 1'b1 || clr_if.wdata !== 32'd0) clr_bad++;
            end
            if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l)) stab_viol++;
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                beat_d.push_back(m_data); beat_l.push_back(m_last); beat_c.push_back(cyc); n_hs++;
            end
            if (n_iss - n_hs > 2) credit_viol++;
            if (done) done_c.push_back(cyc);
            if (busy) busy_cnt++;
        end
    end

    // Reference: a job over [b, b+l) modulo 2^10 yields RAM words in address order, last on the l-th
    int          exp_a[$];
    logic [31:0] exp_d[$];
    bit          exp_l[$];

    task automatic do_job(input int b, input int l, input bit c, input int rmode,
                          input int extra_at, input int budget);
        clear_log();
        rdy_mode = rmode;
        exp_a.delete(); exp_d.delete(); exp_l.delete();
        for (int i = 0; i < l; i++) begin
            exp_a.push_back((b + i) % 1024);
            exp_d.push_back(ram[(b + i) % 1024]);
            exp_l.push_back(i == l - 1);
        end
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'(b); len = 11'(l); clear_en = c; t_start = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 10'($urandom); len = 11'($urandom); clear_en = 1'($urandom);
        if (extra_at >= 0) begin
            repeat (extra_at) @(posedge clk);
            #1; start = 1'b1; base_addr = 10'd100; len = 11'd5; clear_en = 1'b1;
            @(posedge clk); #1; start = 1'b0;
        end
        for (int i = 0; i < budget; i++) begin
            if (done_c.size() != 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if ({busy, done, m_valid, m_last} !== 4'b0) begin
            n_err++; $display("FAIL reset_ctrl: busy/done/valid/last=%b exp 0000", {busy, done, m_valid, m_last});
        end
        n_vec++; if ({rd_if.en, clr_if.en, clr_if.we} !== 3'b0) begin
            n_err++; $display("FAIL reset_ports: rd_en/clr_en/clr_we=%b exp 000", {rd_if.en, clr_if.en, clr_if.we});
        end
        n_vec++; if (m_data !== 32'd0) begin
            n_err++; $display("FAIL reset_data: m_data=%h exp 0", m_data);
        end
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) ram[i] = 32'(i + 1);
        do_job(0, 4, 1'b0, 0, -1, 40);
        n_vec++; if (rd_c.size() == 0 || rd_c[0] != t_start + 1) begin
            n_err++; $display("FAIL basic_first_read: cycle=%0d exp %0d", (rd_c.size() != 0) ? rd_c[0] - t_start : -1, 1);
        end
        n_vec++; if (first_valid != t_start + 3) begin
            n_err++; $display("FAIL basic_latency: m_valid at T+%0d exp T+3", first_valid - t_start);
        end
        n_vec++; if (beat_d.size() != 4) begin
            n_err++; $display("FAIL basic_count: beats=%0d exp 4", beat_d.size());
        end
        for (int i = 0; i < 4 && i < beat_d.size(); i++) begin
            n_vec++; if (beat_d[i] !== exp_d[i] || beat_l[i] !== exp_l[i] || beat_c[i] != t_start + 3 + i) begin
                n_err++; $display("FAIL basic_beat%0d: data=%0d last=%0b at T+%0d exp data=%0d last=%0b at T+%0d",
                                  i, beat_d[i], beat_l[i], beat_c[i] - t_start, exp_d[i], exp_l[i], 3 + i);
            end
        end
        n_vec++; if (done_c.size() != 1 || done_c[0] != t_start + 7) begin
            n_err++; $display("FAIL basic_done: pulses=%0d first at T+%0d exp 1 at T+7", done_c.size(),
                              (done_c.size() != 0) ? done_c[0] - t_start : -1);
        end
        n_vec++; if (busy !== 1'b0) begin
            n_err++; $display("FAIL basic_busy_after: busy=%b exp 0", busy);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) ram[i] = 32'(i + 1);
        do_job(0, 4, 1'b0, 1, -1, 80);
        n_vec++; if (beat_d.size() != 4) begin
            n_err++; $display("FAIL stall_count: beats=%0d exp 4", beat_d.size());
        end
        for (int i = 0; i < 4 && i < beat_d.size(); i++) begin
            n_vec++; if (beat_d[i] !== exp_d[i] || beat_l[i] !== exp_l[i]) begin
                n_err++; $display("FAIL stall_beat%0d: data=%0d last=%0b exp data=%0d last=%0b",
                                  i, beat_d[i], beat_l[i], exp_d[i], exp_l[i]);
            end
        end
        n_vec++; if (stab_viol != 0) begin
            n_err++; $display("FAIL stall_stable: violations=%0d exp 0", stab_viol);
        end
        n_vec++; if (credit_viol != 0 || rd_a.size() != 4) begin
            n_err++; $display("FAIL stall_credit: overflows=%0d reads=%0d exp 0 and 4", credit_viol, rd_a.size());
        end
        n_vec++; if (done_c.size() != 1) begin
            n_err++; $display("FAIL stall_done: pulses=%0d exp 1", done_c.size());
        end
    endtask

    task automatic test_len0();
        do_job(5, 0, 1'b0, 0, -1, 10);
        n_vec++; if (done_c.size() != 1 || done_c[0] != t_start + 1) begin
            n_err++; $display("FAIL len0_done: pulses=%0d first at T+%0d exp 1 at T+1", done_c.size(),
                              (done_c.size() != 0) ? done_c[0] - t_start : -1);
        end
        n_vec++; if (busy_cnt != 0 || rd_a.size() != 0 || beat_d.size() != 0) begin
            n_err++; $display("FAIL len0_idle: busy_cycles=%0d reads=%0d beats=%0d exp 0 0 0",
                              busy_cnt, rd_a.size(), beat_d.size());
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 1024; i++) ram[i] = $urandom;
        do_job(1022, 4, 1'b0, 0, -1, 40);
        n_vec++; if (rd_a.size() != 4) begin
            n_err++; $display("FAIL wrap_reads: count=%0d exp 4", rd_a.size());
        end
        for (int i = 0; i < 4 && i < rd_a.size(); i++) begin
            n_vec++; if (rd_a[i] != exp_a[i] || beat_d.size() <= i || beat_d[i] !== exp_d[i]) begin
                n_err++; $display("FAIL wrap_addr%0d: addr=%0d exp %0d", i, rd_a[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_clear();
        ram[8] = 32'd7; ram[9] = 32'd9; ram[10] = 32'd11;
        do_job(8, 2, 1'b1, 0, -1, 40);
        n_vec++; if (beat_d.size() != 2 || beat_d[0] !== 32'd7 || beat_d[1] !== 32'd9) begin
            n_err++; $display("FAIL clear_stream: beats=%0d first=%0d exp 2 beats 7,9", beat_d.size(),
                              (beat_d.size() != 0) ? beat_d[0] : 0);
        end
        n_vec++; if (ram[8] !== 32'd0 || ram[9] !== 32'd0 || ram[10] !== 32'd11) begin
            n_err++; $display("FAIL clear_ram: ram8=%0d ram9=%0d ram10=%0d exp 0 0 11", ram[8], ram[9], ram[10]);
        end
        n_vec++; if (clr_a.size() != 2 || clr_bad != 0) begin
            n_err++; $display("FAIL clear_writes: count=%0d bad=%0d exp 2 and 0", clr_a.size(), clr_bad);
        end
        for (int i = 0; i < 2 && i < clr_a.size() && i < rd_a.size(); i++) begin
            n_vec++; if (clr_a[i] != rd_a[i] || clr_c[i] != rd_c[i] + 1) begin
                n_err++; $display("FAIL clear_timing%0d: addr=%0d at +%0d exp addr=%0d at +1",
                                  i, clr_a[i], clr_c[i] - rd_c[i], rd_a[i]);
            end
        end
        n_vec++; if (done_c.size() != 1 || clr_c.size() == 0 || done_c[0] <= clr_c[clr_c.size()-1]) begin
            n_err++; $display("FAIL clear_before_done: done_pulses=%0d exp 1 after last clear", done_c.size());
        end
    endtask

    task automatic test_random();
        int b, l, errs;
        bit c;
        for (int i = 0; i < 1024; i++) ram[i] = $urandom | 32'h1;
        for (int j = 0; j < 10; j++) begin
            b = $urandom_range(0, 1023);
            l = $urandom_range(1, 40);
            c = 1'($urandom);
            do_job(b, l, c, 2, -1, 8 * l + 40);
            errs = 0;
            for (int i = 0; i < l && i < beat_d.size(); i++) begin
                if (beat_d[i] !== exp_d[i] || beat_l[i] !== exp_l[i]) errs++;
                if (c && ram[exp_a[i]] !== 32'd0) errs++;
            end
            n_vec++; if (beat_d.size() != l || errs != 0 || done_c.size() != 1) begin
                n_err++; $display("FAIL random_job%0d: beats=%0d errs=%0d dones=%0d exp %0d 0 1",
                                  j, beat_d.size(), errs, done_c.size(), l);
            end
            n_vec++; if (stab_viol != 0 || credit_viol != 0 || clr_a.size() != (c ? l : 0)) begin
                n_err++; $display("FAIL random_proto%0d: unstable=%0d overflow=%0d clears=%0d exp 0 0 %0d",
                                  j, stab_viol, credit_viol, clr_a.size(), c ? l : 0);
            end
        end
    endtask

    task automatic test_busy_start_and_reset();
        for (int i = 0; i < 1024; i++) ram[i] = $urandom | 32'h1;
        do_job(40, 8, 1'b0, 0, 2, 60);
        n_vec++; if (beat_d.size() != 8 || done_c.size() != 1 || clr_a.size() != 0 || rd_a.size() != 8) begin
            n_err++; $display("FAIL busy_start: beats=%0d dones=%0d clears=%0d reads=%0d exp 8 1 0 8",
                              beat_d.size(), done_c.size(), clr_a.size(), rd_a.size());
        end
        for (int i = 0; i < 8 && i < beat_d.size(); i++) begin
            n_vec++; if (beat_d[i] !== exp_d[i]) begin
                n_err++; $display("FAIL busy_start_beat%0d: data=%h exp %h", i, beat_d[i], exp_d[i]);
            end
        end
        clear_log();
        rdy_mode = 1;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd300; len = 11'd30; clear_en = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (8) @(posedge clk);
        #2; rstn = 1'b0; #1;
        n_vec++; if ({busy, done, m_valid, m_last, rd_if.en, clr_if.en, clr_if.we} !== 7'b0 || m_data !== 32'd0) begin
            n_err++; $display("FAIL midjob_reset: busy/done/valid/last/rd/clr/we=%b data=%h exp all 0",
                              {busy, done, m_valid, m_last, rd_if.en, clr_if.en, clr_if.we}, m_data);
        end
        repeat (2) @(posedge clk);
        #1; rstn = 1'b1;
        clear_log();
        repeat (6) @(negedge clk);
        n_vec++; if (done_c.size() != 0 || busy_cnt != 0 || beat_d.size() != 0 || rd_a.size() != 0) begin
            n_err++; $display("FAIL post_reset_quiet: dones=%0d busy=%0d beats=%0d reads=%0d exp 0 0 0 0",
                              done_c.size(), busy_cnt, beat_d.size(), rd_a.size());
        end
        do_job(200, 6, 1'b0, 0, -1, 40);
        n_vec++; if (beat_d.size() != 6 || done_c.size() != 1 || first_valid != t_start + 3) begin
            n_err++; $display("FAIL fresh_job: beats=%0d dones=%0d latency=%0d exp 6 1 3",
                              beat_d.size(), done_c.size(), first_valid - t_start);
        end
        for (int i = 0; i < 6 && i < beat_d.size(); i++) begin
            n_vec++; if (beat_d[i] !== exp_d[i] || beat_l[i] !== exp_l[i]) begin
                n_err++; $display("FAIL fresh_beat%0d: data=%h last=%0b exp %h %0b",
                                  i, beat_d[i], beat_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        clear_log();
        test_reset();
        test_basic();
        test_stall();
        test_len0();
        test_wrap();
        test_clear();
        test_random();
        test_busy_start_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
